fp_normalize_round_pipe: RTL and testbench
==========================================

Name: fp_normalize_round_pipe

Overview:
- Parametrised two-stage pipelined normaliser/rounder for the FP adder datapath.
- Accepts the un-normalised post-add significand, biased exponent, sign and sticky. Returns a packed IEEE-754 result.
- Adds valid/ready flow control, four rounding modes, round-carry renormalisation, overflow saturation and underflow flush-to-zero.
- Generalised over exponent and fraction widths.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (hidden bit excluded).
- BIAS, 2**(EXP_W-1)-1, exponent bias.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_sign  in  1  result sign.
- in_exp  in  EXP_W+2  signed biased exponent of the hidden-bit position.
- in_mant  in  MAN_W+4  layout {carry, hidden, fraction[MAN_W-1:0], guard, round}.
- in_sticky  in  1  OR of all bits below round.
- in_rm  in  2  rounding mode: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  1+EXP_W+MAN_W  {sign, exponent, fraction}.

Behaviour:
- Reset (async, active-high) clears both stage valids and all datapath registers: in_ready=1, out_valid=0, out_result=0. Reset mid-operation discards in-flight beats; no partial output.
- Handshake:
  - A beat transfers on in_valid&&in_ready; a result transfers on out_valid&&out_ready.
  - Stage 2 loads when empty or out_ready. Stage 1 advances when stage 2 loads.
  - in_ready = !s1_valid || s1_advance (combinational from out_ready).
  - Latency exactly 2 cycles with out_ready held high; full throughput of 1 beat/cycle.
  - Under backpressure, holds at most 2 beats; out_result stable while out_valid && !out_ready.
  - Fields of in_rm are captured with the beat.
- Stage 1 (normalise):
  - If carry=1: shift right 1, exp+1, shifted-out round bit ORed into sticky.
  - Else: lz = leading zeros from hidden bit downward (0..MAN_W+3).
    - Shift left by min(lz, exp-1) when exp>1, else no shift.
    - exp -= applied shift.
  - All-zero mant with sticky=0 flags exact zero.
- Stage 2 (round):
  - inc rule by mode:
    - RNE: g&&(r||s||lsb).
    - RTZ: 0.
    - RUP: !sign&&(g||r||s).
    - RDN: sign&&(g||r||s).
  - Sum in MAN_W+2 bits. Carry out of hidden forces fraction=0 and exp+1.
- Overflow (exp >= 2**EXP_W-1 after rounding):
  - RNE gives ±inf.
  - RTZ gives ±max-finite.
  - RUP gives +inf for positive, -max-finite for negative.
  - RDN gives -inf for negative, +max-finite for positive.
- Underflow: exp<=0, or hidden bit still 0 after normalise, gives signed zero (flush-to-zero).
- Exact zero gives exponent 0, fraction 0, sign=in_sign.
- All arithmetic on exponent is signed EXP_W+2 bits; no wrap.

Optional Feature:
- Macro: FPNORM_FLAGS_EN.
- Defined:
  - Adds output port out_flags[3:0] = {overflow, underflow, inexact, zero}, registered alongside out_result with the same valid/hold rules.
  - inexact = g||r||s before rounding, or any overflow/underflow.
  - Reset value 0.
- Undefined: port absent, flag logic not synthesised; all other behaviour identical.

Decomposition:
- Package fpnorm_pkg:
  - rounding-mode enum rm_e (RNE, RTZ, RUP, RDN).
  - flag bit index localparams.
  - function building max-finite/inf for given EXP_W, MAN_W.
- One sub-module: fp_lzc, parametrised combinational leading-zero counter of width N returning $clog2(N+1) bits, N when input all zero.

Test Plan (defaults: EXP_W=8, MAN_W=23):
- in_exp=127, in_mant={0,1,23'h0,0,0}, sticky=0, RNE, out_ready=1 -> 2 cycles later out_result=32'h3F800000, out_valid for 1 cycle.
- carry set: in_exp=127, in_mant={1,0,23'h0,0,0} -> 32'h40000000 (exp 128).
- Rounding carry: hidden=1, fraction all ones, guard=1, RNE, exp=127 -> 32'h40000000.
- Tie: frac lsb=0, g=1, r=0, s=0, RNE -> fraction unchanged. Same with lsb=1 -> fraction+1. RTZ never increments. RUP with sign=1 -> no increment.
- Overflow: in_exp=254, all-ones significand, guard=1.
  - RNE -> 32'h7F800000.
  - RTZ -> 32'h7F7FFFFF.
  - sign=1 RUP -> 32'hFF7FFFFF.
- Cancellation: in_exp=127, in_mant with only fraction bit 20 set -> out exponent 124, fraction 0.
- Cancellation: same with in_exp=2 -> zero (flush).
- Flow control:
  - Hold out_ready=0 for 5 cycles while streaming 4 beats -> in_ready drops after 2 accepted; out_result stable. Release -> beats emerge in order, no loss or duplication.
  - Assert reset mid-stream -> out_valid=0 immediately, in_ready=1.

Source files
------------

// File: rtl/fpnorm_pkg.sv
// Shared types and helpers for the FP normalise/round pipeline.
// Holds the rounding-mode encoding, the flag bit positions and the saturation-value builder.
package fpnorm_pkg;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2,
    RDN = 2'd3
  } rm_e;

  // Bit positions inside out_flags.
  localparam int unsigned FLAG_ZERO      = 0;
  localparam int unsigned FLAG_INEXACT   = 1;
  localparam int unsigned FLAG_UNDERFLOW = 2;
  localparam int unsigned FLAG_OVERFLOW  = 3;

  // Widest packed result the helper below can build.
  localparam int unsigned SAT_W = 64;

  // Builds {sign, exponent, fraction} for either +-inf or +-max-finite.
  // Callers keep the low 1+exp_w+man_w bits.
  function automatic logic [SAT_W-1:0] fp_sat_value(input int exp_w, input int man_w,
                                                    input logic sign, input logic inf);
    logic [SAT_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_W; i++) begin
      if (i < man_w) begin
        v[i] = ~inf;
      end else if (i < man_w + exp_w) begin
        // Max-finite clears only the exponent LSB.
        v[i] = (i != man_w) || inf;
      end else if (i == man_w + exp_w) begin
        v[i] = sign;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
// The count is taken from the MSB downward. An all-zero input returns N.
module fp_lzc #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]             i_data,
  output logic [$clog2(N+1)-1:0]   o_count
);

  localparam int unsigned CW = $clog2(N + 1);

  // Scan LSB to MSB so that the highest set bit wins.
  always_comb begin
    o_count = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (i_data[i]) begin
        o_count = CW'(N - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_normalize_round_pipe.sv
// Two-stage normaliser/rounder for the FP adder datapath, with valid/ready flow control.
// Stage 1 normalises the raw significand. Stage 2 rounds, saturates on overflow and
// flushes underflow to zero.
// Optional macro FPNORM_FLAGS_EN adds out_flags = {overflow, underflow, inexact, zero}.
module fp_normalize_round_pipe
  import fpnorm_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W+1:0]         in_exp,
  input  logic [MAN_W+3:0]         in_mant,
  input  logic                     in_sticky,
  input  logic [1:0]               in_rm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result
`ifdef FPNORM_FLAGS_EN
  ,
  output logic [3:0]               out_flags
`endif
);

  localparam int EW = EXP_W + 2;       // signed exponent width
  localparam int SW = MAN_W + 3;       // {hidden, fraction, guard, round}
  localparam int RW = 1 + EXP_W + MAN_W;
  localparam int CW = $clog2(SW + 1);

  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_SAT  = EW'((2**EXP_W) - 1);

  // Stage 1 state
  logic                  r_s1_valid;
  logic                  r_s1_sign;
  logic signed [EW-1:0]  r_s1_exp;
  logic [SW-1:0]         r_s1_sig;
  logic                  r_s1_sticky;
  logic                  r_s1_zero;
  rm_e                   r_s1_rm;

  // Stage 2 state
  logic                  r_s2_valid;
  logic [RW-1:0]         r_s2_result;

  // Normalise wires
  logic [CW-1:0]         w_lz;
  logic signed [EW-1:0]  w_exp_in;
  logic signed [EW-1:0]  w_lz_s;
  logic signed [EW-1:0]  w_exp_m1;
  logic signed [EW-1:0]  w_shift;
  logic signed [EW-1:0]  w_n_exp;
  logic [SW-1:0]         w_n_sig;
  logic                  w_n_sticky;
  logic                  w_n_zero;

  // Round wires
  logic                  w_lsb;
  logic                  w_g;
  logic                  w_r;
  logic                  w_any;
  logic                  w_inc;
  logic                  w_to_inf;
  logic [MAN_W+1:0]      w_sum;
  logic signed [EW-1:0]  w_exp_rnd;
  logic [MAN_W-1:0]      w_frac;
  logic                  w_unf;
  logic                  w_ovf;
  logic [SAT_W-1:0]      w_sat;
  logic [RW-1:0]         w_result;

  logic                  w_s2_load;
  logic                  w_unused;

  // The datapath works on biased exponents directly, so BIAS never enters the logic.
  assign w_unused = ^{BIAS, w_sum[MAN_W], w_sat[SAT_W-1:RW]};

  assign w_s2_load  = !r_s2_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_load;
  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;

  fp_lzc #(
    .N (SW)
  ) u_lzc (
    .i_data  (in_mant[SW-1:0]),
    .o_count (w_lz)
  );

  // Stage 1: shift right on carry, otherwise shift left as far as the exponent allows.
  always_comb begin
    w_exp_in   = $signed(in_exp);
    w_lz_s     = $signed(EW'(w_lz));
    w_exp_m1   = w_exp_in - EXP_ONE;
    w_shift    = EXP_ZERO;
    w_n_sig    = in_mant[SW-1:0];
    w_n_exp    = w_exp_in;
    w_n_sticky = in_sticky;
    if (w_exp_in > EXP_ONE) begin
      w_shift = (w_lz_s < w_exp_m1) ? w_lz_s : w_exp_m1;
    end
    if (in_mant[SW]) begin
      w_n_sig    = in_mant[SW:1];
      w_n_exp    = w_exp_in + EXP_ONE;
      w_n_sticky = in_sticky | in_mant[0];
    end else begin
      w_n_sig    = in_mant[SW-1:0] << w_shift;
      w_n_exp    = w_exp_in - w_shift;
    end
    w_n_zero = (in_mant == '0) && !in_sticky;
  end

  // Stage 2: rounding increment, post-round carry, saturation and flush selection.
  always_comb begin
    w_lsb = r_s1_sig[2];
    w_g   = r_s1_sig[1];
    w_r   = r_s1_sig[0];
    w_any = w_g | w_r | r_s1_sticky;
    w_inc    = 1'b0;
    w_to_inf = 1'b0;
    unique case (r_s1_rm)
      RNE: begin
        w_inc    = w_g & (w_r | r_s1_sticky | w_lsb);
        w_to_inf = 1'b1;
      end
      RTZ: begin
        w_inc    = 1'b0;
        w_to_inf = 1'b0;
      end
      RUP: begin
        w_inc    = !r_s1_sign & w_any;
        w_to_inf = !r_s1_sign;
      end
      RDN: begin
        w_inc    = r_s1_sign & w_any;
        w_to_inf = r_s1_sign;
      end
      default: begin
        w_inc    = 1'b0;
        w_to_inf = 1'b0;
      end
    endcase
    w_sum     = {1'b0, r_s1_sig[SW-1:2]} + (MAN_W+2)'(w_inc);
    w_exp_rnd = w_sum[MAN_W+1] ? (r_s1_exp + EXP_ONE) : r_s1_exp;
    w_frac    = w_sum[MAN_W+1] ? '0 : w_sum[MAN_W-1:0];
    w_unf     = !r_s1_zero && ((r_s1_exp <= EXP_ZERO) || !r_s1_sig[SW-1]);
    w_ovf     = !r_s1_zero && !w_unf && (w_exp_rnd >= EXP_SAT);
    w_sat     = fp_sat_value(EXP_W, MAN_W, r_s1_sign, w_to_inf);
    if (r_s1_zero || w_unf) begin
      w_result = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (w_ovf) begin
      w_result = w_sat[RW-1:0];
    end else begin
      w_result = {r_s1_sign, w_exp_rnd[EXP_W-1:0], w_frac};
    end
  end

  // Stage 1 register: loads a new beat, or empties, whenever the input is ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_exp    <= '0;
      r_s1_sig    <= '0;
      r_s1_sticky <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_rm     <= RNE;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign   <= in_sign;
        r_s1_exp    <= w_n_exp;
        r_s1_sig    <= w_n_sig;
        r_s1_sticky <= w_n_sticky;
        r_s1_zero   <= w_n_zero;
        r_s1_rm     <= rm_e'(in_rm);
      end
    end
  end

  // Stage 2 register: holds its result while downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_result;
      end
    end
  end

`ifdef FPNORM_FLAGS_EN
  logic [3:0] r_s2_flags;
  logic [3:0] w_flags;

  // Flags are computed from the same stage-1 beat as the result.
  always_comb begin
    w_flags                 = '0;
    w_flags[FLAG_OVERFLOW]  = w_ovf;
    w_flags[FLAG_UNDERFLOW] = w_unf;
    w_flags[FLAG_INEXACT]   = w_any | w_ovf | w_unf;
    w_flags[FLAG_ZERO]      = r_s1_zero | w_unf;
  end

  // Flags follow exactly the same load/hold rules as out_result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_flags <= '0;
    end else if (w_s2_load && r_s1_valid) begin
      r_s2_flags <= w_flags;
    end
  end

  assign out_flags = r_s2_flags;
`endif

endmodule

// File: tb/tb_fp_normalize_round_pipe.sv
// Scoreboard bench for fp_normalize_round_pipe (EXP_W=8, MAN_W=23).
// Expected results come from directed constants or from an integer reference model.
module tb_fp_normalize_round_pipe;

  typedef struct {
    logic   sign;
    int     exp;
    longint mant;
    logic   sticky;
    int     rm;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [26:0] in_mant;
  logic        in_sticky;
  logic [1:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
`ifdef FPNORM_FLAGS_EN
  logic [3:0]  out_flags;
`endif

  int          n_vec;
  int          n_bad;
  int          bp_mode;
  logic [31:0] exp_q[$];
  logic        stall_q;
  logic [31:0] held_q;

  fp_normalize_round_pipe #(
    .EXP_W (8),
    .MAN_W (23)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_sticky  (in_sticky),
    .in_rm      (in_rm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
`ifdef FPNORM_FLAGS_EN
    ,
    .out_flags  (out_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream readiness changes just after the rising edge.
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom % 4) != 0;
    endcase
  end

  // Reference model: value = mant * 2^(exp - bias - 25), normalised and rounded per mode.
  function automatic logic [31:0] model(input beat_t b);
    longint sig;
    longint q;
    int     e;
    int     p;
    int     want;
    int     allowed;
    int     rem;
    logic   s;
    logic   any;
    logic   up;
    logic   to_inf;
    logic [31:0] res;
    s = b.sticky;
    if (b.mant == 0 && !b.sticky) return {b.sign, 31'h0};
    p = -1;
    for (int i = 0; i < 27; i++) if (((b.mant >> i) & 1) == 1) p = i;
    if (p == 26) begin
      sig = b.mant >> 1;
      s   = s | ((b.mant & 1) == 1);
      e   = b.exp + 1;
    end else begin
      want    = 25 - p;
      allowed = 0;
      if (b.exp > 1) allowed = (want < b.exp - 1) ? want : b.exp - 1;
      sig = b.mant << allowed;
      e   = b.exp - allowed;
    end
    if (e <= 0 || ((sig >> 25) & 1) == 0) return {b.sign, 31'h0};
    q   = sig >> 2;
    rem = int'(sig & 3);
    any = (rem != 0) || s;
    case (b.rm)
      0:       up = (rem == 3) || (rem == 2 && (s || (q % 2 == 1)));
      1:       up = 1'b0;
      2:       up = !b.sign && any;
      default: up = b.sign && any;
    endcase
    if (up) q = q + 1;
    if (q == (64'sd1 << 24)) begin
      q = 64'sd1 << 23;
      e = e + 1;
    end
    if (e >= 255) begin
      to_inf = (b.rm == 0) || (b.rm == 2 && !b.sign) || (b.rm == 3 && b.sign);
      return to_inf ? {b.sign, 8'hFF, 23'h0} : {b.sign, 8'hFE, 23'h7FFFFF};
    end
    res = {b.sign, e[7:0], q[22:0]};
    return res;
  endfunction

  function automatic beat_t mk(input logic sign, input int exp, input longint mant,
                               input logic sticky, input int rm);
    beat_t b;
    b.sign = sign; b.exp = exp; b.mant = mant; b.sticky = sticky; b.rm = rm;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    longint m;
    m = (longint'($urandom) << 32 | longint'($urandom)) & 64'h7FF_FFFF;
    case ($urandom % 5)
      0:       m = m >> $urandom_range(1, 27);
      1:       m = m & 64'h3FF_FFFF;
      2:       m = 64'h3FF_FFFC | longint'($urandom % 4);
      default: ;
    endcase
    b.sign   = $urandom % 2;
    b.exp    = ($urandom % 8 == 0) ? int'($urandom_range(0, 10)) - 4
                                   : int'($urandom_range(1, 262));
    b.mant   = m;
    b.sticky = $urandom % 2;
    b.rm     = $urandom % 4;
    return b;
  endfunction

  task automatic apply(input beat_t b);
    in_sign   = b.sign;
    in_exp    = b.exp[9:0];
    in_mant   = b.mant[26:0];
    in_sticky = b.sticky;
    in_rm     = b.rm[1:0];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the beat is accepted.
  task automatic drive(input beat_t b, input logic [31:0] expv);
    int cnt;
    apply(b);
    in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0, expected 1 within 100 cycles");
    end else begin
      exp_q.push_back(expv);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks hold stability under stall.
  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", {31'h0, out_valid}, 32'h1);
        check("hold_result", out_result, held_q);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", out_result, 32'hxxxx_xxxx);
        end else begin
          check("result", out_result, exp_q.pop_front());
        end
      end
      stall_q = out_valid && !out_ready;
      held_q  = out_result;
    end
  end

  localparam longint ONE_H  = 64'sd1 << 25;            // hidden bit only
  localparam longint FULL_G = 64'h3FF_FFFE;            // hidden + all-ones fraction + guard

  initial begin
    beat_t b;
    int k;
    n_vec = 0; n_bad = 0; bp_mode = 0;
    stall_q = 1'b0; held_q = '0;
    reset = 1'b1; in_valid = 1'b0;
    apply(mk(1'b0, 0, 0, 1'b0, 0));
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_result", out_result, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Two-cycle latency, single-cycle valid.
    drive(mk(1'b0, 127, ONE_H, 1'b0, 0), 32'h3F80_0000);
    in_valid = 1'b0;
    check("lat_early", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    check("lat_valid", {31'h0, out_valid}, 32'h1);
    check("lat_result", out_result, 32'h3F80_0000);
    @(negedge clk);
    check("lat_one_cycle", {31'h0, out_valid}, 32'h0);

    // Directed corner cases, streamed back to back.
    drive(mk(1'b0, 127, 64'sd1 << 26, 1'b0, 0), 32'h4000_0000);           // carry
    drive(mk(1'b0, 127, FULL_G, 1'b0, 0), 32'h4000_0000);                 // round carry
    drive(mk(1'b0, 127, ONE_H | (64'sd2 << 2) | 2, 1'b0, 0), 32'h3F80_0002); // tie, lsb 0
    drive(mk(1'b0, 127, ONE_H | (64'sd3 << 2) | 2, 1'b0, 0), 32'h3F80_0004); // tie, lsb 1
    drive(mk(1'b0, 127, ONE_H | (64'sd3 << 2) | 3, 1'b1, 1), 32'h3F80_0003); // RTZ
    drive(mk(1'b1, 127, ONE_H | (64'sd3 << 2) | 2, 1'b0, 2), 32'hBF80_0003); // RUP neg
    drive(mk(1'b0, 127, ONE_H | (64'sd3 << 2), 1'b1, 2), 32'h3F80_0004);     // RUP pos
    drive(mk(1'b1, 127, ONE_H | (64'sd3 << 2), 1'b1, 3), 32'hBF80_0004);     // RDN neg
    drive(mk(1'b0, 254, FULL_G, 1'b0, 0), 32'h7F80_0000);                 // ovf RNE
    drive(mk(1'b0, 254, FULL_G, 1'b0, 1), 32'h7F7F_FFFF);                 // ovf RTZ
    drive(mk(1'b1, 254, FULL_G, 1'b0, 2), 32'hFF7F_FFFF);                 // ovf RUP neg
    drive(mk(1'b0, 254, FULL_G, 1'b0, 3), 32'h7F7F_FFFF);                 // ovf RDN pos
    drive(mk(1'b1, 254, FULL_G, 1'b0, 3), 32'hFF80_0000);                 // ovf RDN neg
    drive(mk(1'b0, 127, 64'sd1 << 22, 1'b0, 0), 32'h3E00_0000);           // cancellation
    drive(mk(1'b0, 2, 64'sd1 << 22, 1'b0, 0), 32'h0000_0000);             // flush
    drive(mk(1'b1, 100, 0, 1'b0, 0), 32'h8000_0000);                      // exact zero
    in_valid = 1'b0;
    drain(50);

    // Backpressure: four beats offered while the output is stalled for five cycles.
    bp_mode = 1;
    repeat (2) @(negedge clk);
    k = 0;
    for (int c = 0; c < 5; c++) begin
      b = mk(c[0], 120 + k, ONE_H | longint'(k * 37 + 5), 1'b0, 0);
      apply(b);
      in_valid = 1'b1;
      if (in_ready) begin
        exp_q.push_back(model(b));
        k++;
      end
      @(negedge clk);
    end
    check("bp_accepted", k, 2);
    check("bp_in_ready", {31'h0, in_ready}, 32'h0);
    bp_mode = 0;
    while (k < 4) begin
      b = mk(k[0], 120 + k, ONE_H | longint'(k * 37 + 5), 1'b0, 0);
      drive(b, model(b));
      k++;
    end
    in_valid = 1'b0;
    drain(50);

    // Reset in the middle of a stream discards both stages.
    b = rand_beat();
    drive(b, model(b));
    b = rand_beat();
    drive(b, model(b));
    #2;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("mid_rst_result", out_result, 32'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {31'h0, out_valid}, 32'h0);

    // Randomised traffic with random downstream stalls.
    bp_mode = 2;
    for (int n = 0; n < 400; n++) begin
      b = rand_beat();
      drive(b, model(b));
      if ($urandom % 5 == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    drain(1000);
    bp_mode = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
